// File: rtl/cpu_mem_arbiter_pkg.sv
// rtl/cpu_mem_arbiter_pkg.sv - shared types and constants for the cpu memory arbiter
package cpu_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ACCESS  = 2'd1,
    ARB_RESPOND = 2'd2
  } arb_state_e;

  localparam logic RDWR_READ  = 1'b0;
  localparam logic RDWR_WRITE = 1'b1;

  // Wide enough for the full 0..15 wait-state range.
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/cpu_mem_arb_pick.sv
// rtl/cpu_mem_arb_pick.sv - combinational two-way request picker
module cpu_mem_arb_pick
  import cpu_mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  input  logic fixed_priority,
  output logic grant_valid,
  output logic grant
);

  always_comb begin
    grant_valid = req0 | req1;
    grant       = 1'b0;
    // On a tie, round-robin hands the bus to whoever did not have it last.
    if (req0 && req1) begin
      grant = fixed_priority ? 1'b0 : ~last_owner;
    end else if (req1) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - shares one synchronous memory port between two bus requesters
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int WAIT_STATES    = 1,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_req,
  input  logic                  r0_which_rdwr,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_ack,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_which_rdwr,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_ack,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  owner
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

  arb_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  logic                  busy_q, busy_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  r0_ack_q, r0_ack_d;
  logic                  r1_ack_q, r1_ack_d;
  logic [DATA_WIDTH-1:0] r0_rdata_q, r0_rdata_d;
  logic [DATA_WIDTH-1:0] r1_rdata_q, r1_rdata_d;
  logic                  grant_valid;
  logic                  grant;

  cpu_mem_arb_pick u_pick (
    .req0           (r0_req),
    .req1           (r1_req),
    .last_owner     (last_owner_q),
    .fixed_priority (FIXED_PRIORITY != 0),
    .grant_valid    (grant_valid),
    .grant          (grant)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    busy_d       = busy_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    r0_ack_d     = 1'b0;
    r1_ack_d     = 1'b0;
    r0_rdata_d   = r0_rdata_q;
    r1_rdata_d   = r1_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        busy_d = 1'b0;
        if (grant_valid) begin
          state_d      = ARB_ACCESS;
          cnt_d        = WAIT_INIT;
          owner_d      = grant;
          last_owner_d = grant;
          busy_d       = 1'b1;
          mem_en_d     = 1'b1;
          mem_we_d     = grant ? r1_which_rdwr : r0_which_rdwr;
          mem_addr_d   = grant ? r1_addr : r0_addr;
          mem_wdata_d  = grant ? r1_wdata : r0_wdata;
        end
      end
      ARB_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Last access cycle: memory read data is valid now.
          state_d  = ARB_RESPOND;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (owner_q) begin
            r1_ack_d = 1'b1;
            if (mem_we_q == RDWR_READ) r1_rdata_d = mem_rdata;
          end else begin
            r0_ack_d = 1'b1;
            if (mem_we_q == RDWR_READ) r0_rdata_d = mem_rdata;
          end
        end
      end
      ARB_RESPOND: begin
        state_d = ARB_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ARB_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      busy_q       <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      r0_ack_q     <= 1'b0;
      r1_ack_q     <= 1'b0;
      r0_rdata_q   <= '0;
      r1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      busy_q       <= busy_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      r0_ack_q     <= r0_ack_d;
      r1_ack_q     <= r1_ack_d;
      r0_rdata_q   <= r0_rdata_d;
      r1_rdata_q   <= r1_rdata_d;
    end
  end

  assign r0_ack    = r0_ack_q;
  assign r1_ack    = r1_ack_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb/tb_cpu_mem_arbiter.sv - table, directed and randomized checks of cpu_mem_arbiter
module tb_cpu_mem_arbiter;

  localparam int NI = 4;
  // Instances 0..3: (WS=1,RR) (WS=1,fixed) (WS=0,RR) (WS=3,RR)
  localparam logic [15:0] WS_P = {4'd3, 4'd0, 4'd1, 4'd1};
  localparam logic [3:0]  FP_P = 4'b0010;

  logic clk = 1'b0;
  logic rst;
  logic r0_req, r0_rw, r1_req, r1_rw;
  logic [15:0] r0_addr, r1_addr;
  logic [7:0]  r0_wdata, r1_wdata;
  logic [NI-1:0] r0_ack, r1_ack, mem_en, mem_we, busy, owner;
  logic [15:0] mem_addr [NI];
  logic [7:0]  mem_wdata [NI];
  logic [7:0]  mem_rdata [NI];
  logic [7:0]  r0_rdata [NI];
  logic [7:0]  r1_rdata [NI];
  logic        rd_ovr;
  logic [7:0]  rd_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign mem_rdata[g] = rd_ovr ? rd_val : mem_fn(mem_addr[g]);
    cpu_mem_arbiter #(
      .ADDR_WIDTH     (16),
      .DATA_WIDTH     (8),
      .WAIT_STATES    (int'(WS_P[g*4 +: 4])),
      .FIXED_PRIORITY (int'(FP_P[g]))
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .r0_req        (r0_req),
      .r0_which_rdwr (r0_rw),
      .r0_addr       (r0_addr),
      .r0_wdata      (r0_wdata),
      .r0_ack        (r0_ack[g]),
      .r0_rdata      (r0_rdata[g]),
      .r1_req        (r1_req),
      .r1_which_rdwr (r1_rw),
      .r1_addr       (r1_addr),
      .r1_wdata      (r1_wdata),
      .r1_ack        (r1_ack[g]),
      .r1_rdata      (r1_rdata[g]),
      .mem_en        (mem_en[g]),
      .mem_we        (mem_we[g]),
      .mem_addr      (mem_addr[g]),
      .mem_wdata     (mem_wdata[g]),
      .mem_rdata     (mem_rdata[g]),
      .busy          (busy[g]),
      .owner         (owner[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ack_of(input int s, input logic p);
    return p ? r1_ack[s] : r0_ack[s];
  endfunction

  function automatic logic [7:0] rdata_of(input int s, input logic p);
    return p ? r1_rdata[s] : r0_rdata[s];
  endfunction

  task automatic drive(input logic p, input logic req, input logic we,
                       input logic [15:0] a, input logic [7:0] d);
    if (p) begin
      r1_req = req; r1_rw = we; r1_addr = a; r1_wdata = d;
    end else begin
      r0_req = req; r0_rw = we; r0_addr = a; r0_wdata = d;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    rd_ovr = 1'b0;
    rd_val = 8'h0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic rand_cmd(input logic p, input logic req);
    drive(p, req, 1'($urandom_range(1)), 16'($urandom), 8'($urandom));
  endtask

  // Transaction-level model: a grant decided in idle cycle c occupies memory in
  // cycles c+1..c+ws+1, acks in c+ws+2, and the arbiter is idle again at c+ws+3.
  task automatic run_random(input int sel, input int ncyc);
    int ws, next_idle, g_cyc;
    logic fp, active, last, own_m, g_port, g_we, gp;
    logic [15:0] g_addr;
    logic [7:0] g_wd;
    logic [7:0] rd_exp [2];
    int phase [2];
    logic e_en, e_we, e_a0, e_a1, e_busy;
    ws = int'(WS_P[sel*4 +: 4]);
    fp = FP_P[sel];
    do_reset();
    next_idle = 0; g_cyc = 0; active = 1'b0; last = 1'b1; own_m = 1'b0;
    g_port = 1'b0; g_we = 1'b0; g_addr = '0; g_wd = '0;
    rd_exp[0] = 8'h0; rd_exp[1] = 8'h0; phase[0] = 0; phase[1] = 0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (cyc > 0) step();
      e_en = 0; e_we = 0; e_a0 = 0; e_a1 = 0; e_busy = 0;
      if (active && cyc == g_cyc + 1) own_m = g_port;
      if (active && cyc > g_cyc && cyc <= g_cyc + ws + 1) begin
        e_en = 1; e_we = g_we; e_busy = 1;
      end else if (active && cyc == g_cyc + ws + 2) begin
        e_busy = 1;
        if (g_port) e_a1 = 1; else e_a0 = 1;
        if (!g_we) rd_exp[g_port] = mem_fn(g_addr);
      end
      chk("rnd_ctrl", {mem_en[sel], mem_we[sel], r0_ack[sel], r1_ack[sel], busy[sel], owner[sel]},
          {e_en, e_we, e_a0, e_a1, e_busy, own_m});
      if (e_en) chk("rnd_cmd", {mem_addr[sel], mem_wdata[sel]}, {g_addr, g_wd});
      chk("rnd_rdata", {r0_rdata[sel], r1_rdata[sel]}, {rd_exp[0], rd_exp[1]});
      for (int p = 0; p < 2; p++) begin
        if (phase[p] == 2) begin
          if (cyc == g_cyc + ws + 2) begin
            if ($urandom_range(1) == 1) begin
              rand_cmd(1'(p), 1'b1); phase[p] = 1;
            end else begin
              rand_cmd(1'(p), 1'b0); phase[p] = 0;
            end
          end else begin
            rand_cmd(1'(p), 1'($urandom_range(1)));
          end
        end else if (phase[p] == 0) begin
          if ($urandom_range(2) == 0) begin
            rand_cmd(1'(p), 1'b1); phase[p] = 1;
          end else begin
            rand_cmd(1'(p), 1'b0);
          end
        end
      end
      if (cyc == next_idle) begin
        if (r0_req || r1_req) begin
          if (r0_req && r1_req) gp = fp ? 1'b0 : ~last;
          else gp = r1_req;
          last = gp; active = 1'b1; g_cyc = cyc; g_port = gp;
          g_we = gp ? r1_rw : r0_rw;
          g_addr = gp ? r1_addr : r0_addr;
          g_wd = gp ? r1_wdata : r0_wdata;
          phase[gp] = 2;
          next_idle = cyc + ws + 3;
        end else begin
          next_idle = cyc + 1;
        end
      end
    end
  endtask

  typedef struct {
    int          sel;
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdv;
    int          exp_lat;
    logic [7:0]  exp_rd;
  } vec_t;

  localparam int NV = 6;
  vec_t vt [NV];

  initial begin
    int lat, en_cnt, n_ack;
    logic cmd_ok, other, seen;
    int ack_port [4];
    int ack_cyc [4];

    vt[0] = '{0, 1'b0, 1'b0, 16'h2329, 8'h00, 8'hA5, 3, 8'hA5};
    vt[1] = '{0, 1'b1, 1'b1, 16'h9001, 8'h5C, 8'h11, 3, 8'h00};
    vt[2] = '{2, 1'b0, 1'b0, 16'h1234, 8'h00, 8'h3C, 2, 8'h3C};
    vt[3] = '{3, 1'b0, 1'b0, 16'hBEEF, 8'h00, 8'h77, 5, 8'h77};
    vt[4] = '{1, 1'b1, 1'b0, 16'h0001, 8'h00, 8'hFF, 3, 8'hFF};
    vt[5] = '{3, 1'b1, 1'b1, 16'hFFFF, 8'h81, 8'h22, 5, 8'h00};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    rd_ovr = 1'b0;
    rd_val = 8'h0;
    step();
    for (int s = 0; s < NI; s++) begin
      chk("reset_ctrl", {r0_ack[s], r1_ack[s], mem_en[s], mem_we[s], busy[s], owner[s]}, 0);
      chk("reset_data", {mem_addr[s], mem_wdata[s], r0_rdata[s], r1_rdata[s]}, 0);
    end
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      do_reset();
      rd_ovr = 1'b1;
      rd_val = vt[i].rdv;
      drive(vt[i].port, 1'b1, vt[i].we, vt[i].addr, vt[i].wdata);
      lat = 0; en_cnt = 0; cmd_ok = 1'b1; other = 1'b0;
      for (int n = 1; n <= 20; n++) begin
        step();
        if (mem_en[vt[i].sel]) begin
          en_cnt++;
          if (mem_we[vt[i].sel] !== vt[i].we || mem_addr[vt[i].sel] !== vt[i].addr ||
              mem_wdata[vt[i].sel] !== vt[i].wdata) cmd_ok = 1'b0;
        end
        if (ack_of(vt[i].sel, ~vt[i].port)) other = 1'b1;
        if (ack_of(vt[i].sel, vt[i].port)) begin
          lat = n;
          break;
        end
      end
      chk("vec_latency", lat, vt[i].exp_lat);
      chk("vec_en_cycles", en_cnt, vt[i].exp_lat - 1);
      chk("vec_cmd", cmd_ok, 1);
      chk("vec_rdata", rdata_of(vt[i].sel, vt[i].port), vt[i].exp_rd);
      chk("vec_other_ack", other, 0);
      drive(vt[i].port, 1'b0, 1'b0, 16'h0, 8'h0);
      step();
      chk("vec_ack_pulse", {ack_of(vt[i].sel, vt[i].port), busy[vt[i].sel]}, 0);
    end

    // Both ports hold read requests continuously.
    for (int s = 0; s < 2; s++) begin
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 16'h0100, 8'h0);
      drive(1'b1, 1'b1, 1'b0, 16'h0200, 8'h0);
      n_ack = 0;
      for (int k = 0; k < 4; k++) begin ack_port[k] = 2; ack_cyc[k] = 0; end
      for (int n = 1; n <= 40 && n_ack < 4; n++) begin
        step();
        if (r0_ack[s] || r1_ack[s]) begin
          ack_port[n_ack] = r1_ack[s] ? 1 : 0;
          ack_cyc[n_ack] = n;
          n_ack++;
        end
      end
      chk("alt_first_cycle", ack_cyc[0], 3);
      for (int k = 0; k < 4; k++) begin
        chk("alt_port", ack_port[k], (s == 0) ? (k % 2) : 0);
        if (k > 0) chk("alt_spacing", ack_cyc[k] - ack_cyc[k-1], 4);
      end
    end

    // Asynchronous reset in the middle of a WS=3 access.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 16'h4242, 8'h0);
    step();
    step();
    chk("arst_pre_en", mem_en[3], 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_ctrl", {r0_ack[3], r1_ack[3], mem_en[3], mem_we[3], busy[3], owner[3]}, 0);
    chk("arst_addr", mem_addr[3], 0);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 16'h0300, 8'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0400, 8'h0);
    lat = 0; seen = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (r0_ack[3] || r1_ack[3]) begin
        lat = n;
        seen = r1_ack[3];
        break;
      end
    end
    chk("arst_tie_latency", lat, 5);
    chk("arst_tie_port", seen, 0);

    for (int s = 0; s < NI; s++) run_random(s, 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
